// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions, ExcCode values.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam int IM_HI   = 15;
   localparam int IM_LO   = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;
   localparam int BD_BIT  = 31;
   localparam int IP_HI   = 15;
   localparam int IP_LO   = 10;
   localparam int EXC_HI  = 6;
   localparam int EXC_LO  = 2;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // A delay-slot victim restarts at its branch, one word earlier.
   function automatic logic [29:0] epc_word(input logic [31:0] pc, input logic bd);
      return bd ? (pc[31:2] - 30'd1) : pc[31:2];
   endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Combinational interrupt/exception arbiter: decides whether the M-stage
// instruction is redirected and which ExcCode gets latched into Cause.
module cp0_int_arb
   import cp0_pkg::*;
#(
   parameter int INT_LINES = 6
) (
   input  logic                 valid_m,
   input  logic                 exp_flag_m,
   input  logic [4:0]           exc_code_m,
   input  logic                 ie,
   input  logic                 exl,
   input  logic [INT_LINES-1:0] im,
   input  logic [INT_LINES-1:0] hw_int,
   output logic                 exc,
   output logic [4:0]           exc_code_nxt
);

   logic int_req;
   logic exc_req;

   // Interrupts are only taken on a real instruction so EPC always names one.
   assign int_req      = valid_m & ie & ~exl & (|(hw_int & im));
   assign exc_req      = valid_m & exp_flag_m & ~exl;
   assign exc          = int_req | exc_req;
   assign exc_code_nxt = int_req ? EXC_INT : exc_code_m;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) with exception/interrupt redirect.
// Optional macro CP0_EPC_BYPASS_EN forwards an in-flight mtc0 EPC onto PC_EPC.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID      = 32'h2021_0080,
   parameter int          INT_LINES = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [4:0]           addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic                 valid_m,
   input  logic [31:0]          pc_m,
   input  logic                 bd_m,
   input  logic                 exp_flag_m,
   input  logic [4:0]           exc_code_m,
   input  logic                 eret_m,
   input  logic [INT_LINES-1:0] hw_int,
   output logic                 exc,
   output logic [31:0]          PC_EPC
);

   logic [INT_LINES-1:0] im_q;
   logic [INT_LINES-1:0] ip_q;
   logic                 exl_q;
   logic                 ie_q;
   logic                 bd_q;
   logic [4:0]           exc_code_q;
   logic [29:0]          epc_q;

   logic [4:0]           exc_code_nxt;
   logic                 wr_en;
   logic                 wr_sr;
   logic                 wr_epc;
   logic [31:0]          sr_val;
   logic [31:0]          cause_val;

   cp0_int_arb #(
      .INT_LINES (INT_LINES)
   ) u_arb (
      .valid_m      (valid_m),
      .exp_flag_m   (exp_flag_m),
      .exc_code_m   (exc_code_m),
      .ie           (ie_q),
      .exl          (exl_q),
      .im           (im_q),
      .hw_int       (hw_int),
      .exc          (exc),
      .exc_code_nxt (exc_code_nxt)
   );

   // The victim of a redirect must not commit its mtc0.
   assign wr_en  = we & ~exc;
   assign wr_sr  = wr_en & (addr == REG_SR);
   assign wr_epc = wr_en & (addr == REG_EPC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_q       <= '0;
         ip_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exc_code_q <= 5'd0;
         epc_q      <= 30'd0;
      end else begin
         ip_q <= hw_int;
         if (exc) begin
            // A simultaneous eret is discarded: EXL stays set for the handler.
            exl_q      <= 1'b1;
            exc_code_q <= exc_code_nxt;
            bd_q       <= bd_m;
            epc_q      <= epc_word(pc_m, bd_m);
         end else begin
            if (eret_m) begin
               exl_q <= 1'b0;
            end
            if (wr_sr) begin
               im_q  <= wdata[IM_LO +: INT_LINES];
               exl_q <= wdata[EXL_BIT];
               ie_q  <= wdata[IE_BIT];
            end
            if (wr_epc) begin
               epc_q <= wdata[31:2];
            end
         end
      end
   end

   always_comb begin
      sr_val                     = '0;
      sr_val[IM_LO +: INT_LINES] = im_q;
      sr_val[EXL_BIT]            = exl_q;
      sr_val[IE_BIT]             = ie_q;
   end

   always_comb begin
      cause_val                     = '0;
      cause_val[BD_BIT]             = bd_q;
      cause_val[IP_LO +: INT_LINES] = ip_q;
      cause_val[EXC_HI:EXC_LO]      = exc_code_q;
   end

   // mfc0 sees only committed state; no forwarding from a same-cycle mtc0.
   always_comb begin
      rdata = 32'd0;
      case (addr)
         REG_SR:    rdata = sr_val;
         REG_CAUSE: rdata = cause_val;
         REG_EPC:   rdata = {epc_q, 2'b00};
         REG_PRID:  rdata = PRID;
         default:   rdata = 32'd0;
      endcase
   end

`ifdef CP0_EPC_BYPASS_EN
   assign PC_EPC = wr_epc ? {wdata[31:2], 2'b00} : {epc_q, 2'b00};
`else
   assign PC_EPC = {epc_q, 2'b00};
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations are queued as stimulus is driven
// and compared either in the same cycle or after the following rising edge.
module tb_cp0_unit;

   localparam logic [31:0] PRID_V    = 32'h2021_0080;
   localparam int          SEL_EXC   = 32;
   localparam int          SEL_PCEPC = 33;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        valid_m;
   logic [31:0] pc_m;
   logic        bd_m;
   logic        exp_flag_m;
   logic [4:0]  exc_code_m;
   logic        eret_m;
   logic [5:0]  hw_int;
   logic        exc;
   logic [31:0] PC_EPC;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          due;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   cp0_unit #(
      .PRID      (PRID_V),
      .INT_LINES (6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .valid_m    (valid_m),
      .pc_m       (pc_m),
      .bd_m       (bd_m),
      .exp_flag_m (exp_flag_m),
      .exc_code_m (exc_code_m),
      .eret_m     (eret_m),
      .hw_int     (hw_int),
      .exc        (exc),
      .PC_EPC     (PC_EPC)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_at(input int dly, input int sel, input logic [31:0] v);
      exp_t e;
      e.due = cyc + dly;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      logic [4:0] save;
      exp_t       e;
      save = addr;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.sel == SEL_EXC)
            chk($sformatf("exc@c%0d", cyc), {31'd0, exc}, e.val);
         else if (e.sel == SEL_PCEPC)
            chk($sformatf("pc_epc@c%0d", cyc), PC_EPC, e.val);
         else begin
            addr = e.sel[4:0];
            #1;
            chk($sformatf("cp0r%0d@c%0d", e.sel, cyc), rdata, e.val);
         end
      end
      addr = save;
   endtask

   task automatic idle();
      valid_m    = 1'b0;
      we         = 1'b0;
      exp_flag_m = 1'b0;
      eret_m     = 1'b0;
      bd_m       = 1'b0;
      pc_m       = 32'd0;
      exc_code_m = 5'd0;
      wdata      = 32'd0;
      addr       = 5'd0;
   endtask

   // Inputs were driven at a falling edge; check same-cycle, clock, idle, check.
   task automatic cycle();
      #1 drain();
      @(posedge clk);
      #1 idle();
      drain();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      hw_int = 6'd0;
      idle();
      @(negedge clk);
      expect_at(0, 12, 32'd0);
      expect_at(0, 13, 32'd0);
      expect_at(0, 14, 32'd0);
      expect_at(0, 15, PRID_V);
      expect_at(0, 0,  32'd0);
      expect_at(0, SEL_PCEPC, 32'd0);
      expect_at(0, SEL_EXC, 32'd0);
      drain();
      reset = 1'b0;
      @(negedge clk);

      // AdEL on a non-delay-slot instruction
      valid_m = 1; exp_flag_m = 1; exc_code_m = 5'd4; pc_m = 32'h3001; bd_m = 0;
      expect_at(0, SEL_EXC, 32'd1);
      expect_at(1, 13, 32'h10);
      expect_at(1, 14, 32'h3000);
      expect_at(1, 12, 32'h2);
      expect_at(1, SEL_PCEPC, 32'h3000);
      cycle();

      // EXL set: further exceptions ignored
      valid_m = 1; exp_flag_m = 1; exc_code_m = 5'd12; pc_m = 32'h5000;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 14, 32'h3000);
      expect_at(1, 13, 32'h10);
      cycle();

      // eret: PC_EPC already valid, EXL clears at the edge
      valid_m = 1; eret_m = 1;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(0, SEL_PCEPC, 32'h3000);
      expect_at(1, 12, 32'h0);
      cycle();

      // mtc0 SR: only IM/EXL/IE are writable
      valid_m = 1; we = 1; addr = 5'd12; wdata = 32'hFFFF_0401;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 12, 32'h401);
      cycle();

      // Masked line pending: no interrupt, IP still tracks hw_int
      hw_int = 6'b000010; valid_m = 1; pc_m = 32'h3020;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 13, 32'h810);
      cycle();

      // Interrupt on a delay-slot instruction outranks its RI exception
      hw_int = 6'b000001; valid_m = 1; pc_m = 32'h3010; bd_m = 1;
      exp_flag_m = 1; exc_code_m = 5'd10;
      expect_at(0, SEL_EXC, 32'd1);
      expect_at(1, 13, 32'h8000_0400);
      expect_at(1, 14, 32'h300C);
      expect_at(1, 12, 32'h403);
      cycle();

      hw_int = 6'd0; valid_m = 1; eret_m = 1;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 12, 32'h401);
      expect_at(1, 13, 32'h8000_0000);
      cycle();

      // Bubble with an enabled interrupt pending
      hw_int = 6'b000001; valid_m = 0;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 13, 32'h8000_0400);
      cycle();

      // Exception and mtc0 EPC together: write suppressed
      hw_int = 6'd0; valid_m = 1; exp_flag_m = 1; exc_code_m = 5'd12; pc_m = 32'h7008;
      we = 1; addr = 5'd14; wdata = 32'h3456;
      expect_at(0, SEL_EXC, 32'd1);
      expect_at(0, SEL_PCEPC, 32'h300C);
      expect_at(1, 14, 32'h7008);
      expect_at(1, 13, 32'h30);
      expect_at(1, 12, 32'h403);
      cycle();

      valid_m = 1; eret_m = 1;
      expect_at(1, 12, 32'h401);
      cycle();

      // Exception together with eret: EXL stays set
      valid_m = 1; exp_flag_m = 1; eret_m = 1; exc_code_m = 5'd5; pc_m = 32'h8000;
      expect_at(0, SEL_EXC, 32'd1);
      expect_at(1, 12, 32'h403);
      expect_at(1, 14, 32'h8000);
      expect_at(1, 13, 32'h14);
      cycle();

      // mtc0 EPC: bypass only onto PC_EPC, never onto rdata
      valid_m = 1; we = 1; addr = 5'd14; wdata = 32'h4003;
      expect_at(0, SEL_EXC, 32'd0);
`ifdef CP0_EPC_BYPASS_EN
      expect_at(0, SEL_PCEPC, 32'h4000);
`else
      expect_at(0, SEL_PCEPC, 32'h8000);
`endif
      expect_at(0, 14, 32'h8000);
      expect_at(1, 14, 32'h4000);
      expect_at(1, SEL_PCEPC, 32'h4000);
      cycle();

      // Cause and PRId are read-only
      valid_m = 1; we = 1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
      expect_at(1, 13, 32'h14);
      cycle();
      valid_m = 1; we = 1; addr = 5'd15; wdata = 32'h0;
      expect_at(1, 15, PRID_V);
      cycle();

      // mtc0 clearing EXL takes effect for interrupts one cycle later
      hw_int = 6'b000001; valid_m = 1; we = 1; addr = 5'd12; wdata = 32'h401;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 12, 32'h401);
      cycle();
      valid_m = 1; pc_m = 32'h9004;
      expect_at(0, SEL_EXC, 32'd1);
      expect_at(1, 13, 32'h400);
      expect_at(1, 14, 32'h9004);
      expect_at(1, 12, 32'h403);
      cycle();

      // Asynchronous reset mid-cycle
      #3 reset = 1'b1;
      #1;
      expect_at(0, 12, 32'd0);
      expect_at(0, 13, 32'd0);
      expect_at(0, 14, 32'd0);
      expect_at(0, SEL_PCEPC, 32'd0);
      expect_at(0, SEL_EXC, 32'd0);
      drain();
      @(negedge clk);
      reset = 1'b0;

      // IE cleared by reset: pending interrupt ignored
      valid_m = 1; hw_int = 6'b000001; pc_m = 32'hA000;
      expect_at(0, SEL_EXC, 32'd0);
      expect_at(1, 12, 32'd0);
      expect_at(1, 13, 32'h400);
      cycle();

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
